// File: rtl/draw_pads.sv
// Landing-pad overlay: NUM_PADS textured rectangles with a blinking target pad, 3-clk pipeline.
// Optional build macro PAD_COLORKEY_EN makes texels equal to COLOR_KEY transparent.
module draw_pads #(
  parameter int          NUM_PADS     = 2,
  parameter int          PAD_W        = 115,
  parameter int          PAD_H        = 20,
  parameter int          TILE_BITS    = 4,
  parameter int          ADDR_W       = 12,
  parameter int          BLINK_FRAMES = 16,
  parameter logic [11:0] COLOR_KEY    = 12'h000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PADS-1:0]      pad_en,
  input  logic [11*NUM_PADS-1:0]   pad_x,
  input  logic [11*NUM_PADS-1:0]   pad_y,
  input  logic [NUM_PADS-1:0]      target_sel,
  input  logic [10:0]              hcount_in,
  input  logic [10:0]              vcount_in,
  input  logic                     hsync_in,
  input  logic                     hblnk_in,
  input  logic                     vsync_in,
  input  logic                     vblnk_in,
  input  logic [11:0]              rgb_in,
  output logic [10:0]              hcount_out,
  output logic [10:0]              vcount_out,
  output logic                     hsync_out,
  output logic                     hblnk_out,
  output logic                     vsync_out,
  output logic                     vblnk_out,
  output logic [11:0]              rgb_out,
  output logic [ADDR_W-1:0]        pixel_addr,
  input  logic [11:0]              rgb_pixel,
  output logic                     pad_hit
);

  localparam int HALF = ADDR_W / 2;
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Stage 1 hit search; descending loop so the lowest matching index is written last and wins.
  logic                 hit_d, tgt_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [11:0]          lx, ty;
  logic [TILE_BITS-1:0] dx, dy;

  always_comb begin
    hit_d  = 1'b0;
    tgt_d  = 1'b0;
    addr_d = pixel_addr;
    lx     = '0;
    ty     = '0;
    dx     = '0;
    dy     = '0;
    for (int i = NUM_PADS - 1; i >= 0; i--) begin
      lx = {1'b0, pad_x[11*i +: 11]};
      ty = {1'b0, pad_y[11*i +: 11]};
      dx = hcount_in[TILE_BITS-1:0] - pad_x[11*i +: TILE_BITS];
      dy = vcount_in[TILE_BITS-1:0] - pad_y[11*i +: TILE_BITS];
      if (pad_en[i] &&
          ({1'b0, hcount_in} >= lx) && ({1'b0, hcount_in} < lx + 12'(PAD_W)) &&
          ({1'b0, vcount_in} >= ty) && ({1'b0, vcount_in} < ty + 12'(PAD_H))) begin
        hit_d  = 1'b1;
        tgt_d  = target_sel[i];
        addr_d = '0;
        addr_d[HALF +: TILE_BITS] = dy;
        addr_d[0 +: TILE_BITS]    = dx;
      end
    end
  end

  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            blink_q, blink_d, vs_prev_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (vsync_in && !vs_prev_q) begin
      if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  logic texel_opaque;
`ifdef PAD_COLORKEY_EN
  assign texel_opaque = (rgb_pixel != COLOR_KEY);
`else
  logic unused_color_key;
  assign unused_color_key = ^COLOR_KEY;
  assign texel_opaque     = 1'b1;
`endif

  logic [10:0]       hc1_q, vc1_q, hc2_q, vc2_q, hc3_q, vc3_q;
  logic [3:0]        sy1_q, sy2_q, sy3_q;
  logic [11:0]       rgb1_q, rgb2_q, rgb3_q;
  logic              hit1_q, hit2_q, tgt1_q, tgt2_q, hit3_q;
  logic [ADDR_W-1:0] pixel_addr_q;
  logic              draw;

  // The target bit travels with the pixel so target_sel changes never affect pixels in flight.
  assign draw = hit2_q && !(blink_q && tgt2_q) && texel_opaque;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc1_q <= '0; vc1_q <= '0; sy1_q <= '0; rgb1_q <= '0; hit1_q <= 1'b0; tgt1_q <= 1'b0;
      hc2_q <= '0; vc2_q <= '0; sy2_q <= '0; rgb2_q <= '0; hit2_q <= 1'b0; tgt2_q <= 1'b0;
      hc3_q <= '0; vc3_q <= '0; sy3_q <= '0; rgb3_q <= '0; hit3_q <= 1'b0;
      pixel_addr_q <= '0;
      vs_prev_q    <= 1'b0;
      frame_cnt_q  <= '0;
      blink_q      <= 1'b0;
    end else begin
      hc1_q  <= hcount_in;
      vc1_q  <= vcount_in;
      sy1_q  <= {hsync_in, hblnk_in, vsync_in, vblnk_in};
      rgb1_q <= rgb_in;
      hit1_q <= hit_d;
      tgt1_q <= tgt_d;
      pixel_addr_q <= addr_d;

      hc2_q  <= hc1_q;
      vc2_q  <= vc1_q;
      sy2_q  <= sy1_q;
      rgb2_q <= rgb1_q;
      hit2_q <= hit1_q;
      tgt2_q <= tgt1_q;

      hc3_q  <= hc2_q;
      vc3_q  <= vc2_q;
      sy3_q  <= sy2_q;
      rgb3_q <= draw ? rgb_pixel : rgb2_q;
      hit3_q <= draw;

      vs_prev_q   <= vsync_in;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign hcount_out = hc3_q;
  assign vcount_out = vc3_q;
  assign {hsync_out, hblnk_out, vsync_out, vblnk_out} = sy3_q;
  assign rgb_out    = rgb3_q;
  assign pad_hit    = hit3_q;
  assign pixel_addr = pixel_addr_q;

endmodule

// File: tb/tb_draw_pads.sv
// Bench for draw_pads: reference model feeds a scoreboard, plus a table of boundary pixels.
module tb_draw_pads;

  localparam int NP = 2;
  localparam int BF = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NP-1:0]  pad_en = '0;
  logic [11*NP-1:0] pad_x = '0, pad_y = '0;
  logic [NP-1:0]  target_sel = '0;
  logic [10:0]    hcount_in = '0, vcount_in = '0;
  logic           hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0]    rgb_in = '0;
  logic [10:0]    hcount_out, vcount_out;
  logic           hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0]    rgb_out;
  logic [11:0]    pixel_addr;
  logic [11:0]    rgb_pixel = '0;
  logic           pad_hit;

  draw_pads #(.NUM_PADS(NP), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .pad_en(pad_en), .pad_x(pad_x), .pad_y(pad_y),
    .target_sel(target_sel), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out),
    .vblnk_out(vblnk_out), .rgb_out(rgb_out), .pixel_addr(pixel_addr),
    .rgb_pixel(rgb_pixel), .pad_hit(pad_hit)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Texture ROM: zero only at address 0, always below 12'h800 so it never equals rgb_in.
  function automatic logic [11:0] rom(input logic [11:0] a);
    return {a[5:0], a[11:6]};
  endfunction

  always @(posedge clk) rgb_pixel <= rom(pixel_addr);

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] cyc;
    logic [10:0] h, v;
    logic [3:0]  sy;
    logic [11:0] rgb;
    logic        hit;
  } exp_t;
  typedef struct packed {
    logic [31:0] cyc;
    logic [11:0] addr;
  } aexp_t;

  exp_t  exp_q[$];
  aexp_t addr_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0].cyc + 3 <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hcount_out", 32'(hcount_out), 32'(e.h));
        chk("vcount_out", 32'(vcount_out), 32'(e.v));
        chk("sync_out", 32'({hsync_out, hblnk_out, vsync_out, vblnk_out}), 32'(e.sy));
        chk("rgb_out", 32'(rgb_out), 32'(e.rgb));
        chk("pad_hit", 32'(pad_hit), 32'(e.hit));
      end
      if (addr_q.size() > 0 && addr_q[0].cyc + 1 <= cyc) begin
        aexp_t a;
        a = addr_q.pop_front();
        chk("pixel_addr", 32'(pixel_addr), 32'(a.addr));
      end
    end
  end

  // ---------------- reference model + driver ----------------
  int          frames = 0;
  logic        prev_vs_m = 1'b0;
  logic [11:0] exp_addr_m = '0;

  function automatic int px(input int i); return int'(pad_x[11*i +: 11]); endfunction
  function automatic int py(input int i); return int'(pad_y[11*i +: 11]); endfunction

  // hit_ovr / addr_ovr >= 0 replace the model value with a hand-derived constant.
  task automatic drive(input int h, input int v, input logic vs, input int hit_ovr, input int addr_ovr);
    logic        m_hit, phase, draw;
    int          m_idx;
    logic [11:0] texel, rgb;
    exp_t        e;
    aexp_t       a;
    @(posedge clk); #1;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = 1'($urandom_range(0, 1));
    hblnk_in  = 1'($urandom_range(0, 1));
    vblnk_in  = 1'($urandom_range(0, 1));
    vsync_in  = vs;
    rgb       = {1'b1, 11'(h)};
    rgb_in    = rgb;
    if (vs && !prev_vs_m) frames++;
    prev_vs_m = vs;
    phase = ((frames / BF) % 2) == 1;
    m_hit = 1'b0;
    m_idx = 0;
    for (int i = 0; i < NP; i++) begin
      if (!m_hit && pad_en[i] && h >= px(i) && h < px(i) + 115 && v >= py(i) && v < py(i) + 20) begin
        m_hit = 1'b1;
        m_idx = i;
      end
    end
    if (m_hit) exp_addr_m = 12'((((v - py(m_idx)) % 16) * 64) + ((h - px(m_idx)) % 16));
    texel = rom(exp_addr_m);
    draw  = m_hit && !(phase && target_sel[m_idx]);
`ifdef PAD_COLORKEY_EN
    if (texel == 12'h000) draw = 1'b0;
`endif
    if (hit_ovr >= 0) draw = (hit_ovr != 0);
    e.cyc = cyc;
    e.h   = 11'(h);
    e.v   = 11'(v);
    e.sy  = {hsync_in, hblnk_in, vsync_in, vblnk_in};
    e.rgb = draw ? texel : rgb;
    e.hit = draw;
    exp_q.push_back(e);
    a.cyc  = cyc;
    a.addr = (addr_ovr >= 0) ? 12'(addr_ovr) : exp_addr_m;
    addr_q.push_back(a);
  endtask

  task automatic sweep(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) drive(h, v, 1'b0, -1, -1);
  endtask

  task automatic frame_pulse();
    for (int k = 0; k < 10; k++) drive(k, 0, (k >= 2 && k < 6), -1, -1);
  endtask

  // ---------------- boundary table ----------------
  typedef struct { int h; int v; int hit; } vec_t;
  vec_t vecs[12];

  initial begin
    vecs[0]  = '{9,   565, 0};
    vecs[1]  = '{10,  565, 1};
    vecs[2]  = '{124, 565, 1};
    vecs[3]  = '{125, 565, 0};
    vecs[4]  = '{629, 565, 0};
    vecs[5]  = '{630, 565, 1};
    vecs[6]  = '{744, 565, 1};
    vecs[7]  = '{745, 565, 0};
    vecs[8]  = '{12,  559, 0};
    vecs[9]  = '{12,  560, 1};
    vecs[10] = '{12,  579, 1};
    vecs[11] = '{12,  580, 0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb_out", 32'(rgb_out), 0);
    chk("reset_pad_hit", 32'(pad_hit), 0);
    chk("reset_pixel_addr", 32'(pixel_addr), 0);
    chk("reset_hcount_out", 32'(hcount_out), 0);
    rst = 1'b0;

    // default pads, line 565 sweep with a hand-checked address at hcount 12
    pad_en = 2'b11;
    pad_x  = {11'd630, 11'd10};
    pad_y  = {11'd560, 11'd560};
    target_sel = 2'b00;
    sweep(565, 0, 11);
    drive(12, 565, 1'b0, -1, (5 << 6) | 2);
    sweep(565, 13, 799);

    // timing edges
    for (int i = 0; i < 12; i++) drive(vecs[i].h, vecs[i].v, 1'b0, vecs[i].hit, -1);

    // overlap: pad0 owns 50..124, pad1 addressing from 125
    pad_x = {11'd50, 11'd10};
    sweep(565, 40, 49);
    drive(50, 565, 1'b0, -1, (5 << 6) | 8);
    sweep(565, 51, 124);
    drive(125, 565, 1'b0, -1, (5 << 6) | 11);
    sweep(565, 126, 180);

    // blink on pad1, BF=2: frames 0-1 drawn, 2-3 absent, 4-5 drawn, 6 absent
    pad_x = {11'd630, 11'd10};
    target_sel = 2'b10;
    for (int f = 0; f < 7; f++) begin
      if (f > 0) frame_pulse();
      if (f < 6) begin
        drive(630, 565, 1'b0, (f == 2 || f == 3) ? 0 : 1, -1);
        sweep(565, 0, 799);
      end
    end

    // mid-line reset at hcount 600 of frame 6 (blink phase 1)
    sweep(565, 0, 599);
    drive(600, 565, 1'b0, -1, -1);
    rst = 1'b1;
    #1;
    chk("rst_rgb_out", 32'(rgb_out), 0);
    chk("rst_pad_hit", 32'(pad_hit), 0);
    chk("rst_pixel_addr", 32'(pixel_addr), 0);
    chk("rst_timing", 32'({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}), 0);
    exp_q.delete();
    addr_q.delete();
    frames = 0;
    prev_vs_m = 1'b0;
    exp_addr_m = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    // blink phase restarted at 0, so pad1 is drawn again
    drive(601, 565, 1'b0, -1, -1);
    sweep(565, 602, 629);
    drive(630, 565, 1'b0, 1, -1);
    sweep(565, 631, 799);

    // colour key at pad0 origin (address 0 reads 12'h000)
    target_sel = 2'b00;
    sweep(560, 0, 9);
`ifdef PAD_COLORKEY_EN
    drive(10, 560, 1'b0, 0, 0);
`else
    drive(10, 560, 1'b0, 1, 0);
`endif
    sweep(560, 11, 40);

    // drain
    repeat (6) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size() + addr_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
